// File: rtl/servo_angle_ramp_pkg.sv
// servo_pkg: shared angle type, servo limits, ramp FSM states and target clamp helper
package servo_pkg;
  typedef logic [7:0] angle_t;
  localparam int MAX_ANGLE = 180;
  localparam int NUM_SERVOS = 4;
  typedef enum logic [1:0] {WAIT, STEP, PULSE} ramp_state_t;
  function automatic angle_t clamp_angle(angle_t a);
    return (a > angle_t'(MAX_ANGLE)) ? angle_t'(MAX_ANGLE) : a;
  endfunction
endpackage

// File: rtl/servo_angle_ramp_if.sv
// servo_angle_ramp_if: target handshake (tgt_valid/tgt_ready/tgt_angle1..4) in, commanded angles, nextangle strobe and at_target out
interface servo_angle_ramp_if;
  import servo_pkg::*;
  logic   tgt_valid;
  logic   tgt_ready;
  angle_t tgt_angle1, tgt_angle2, tgt_angle3, tgt_angle4;
  angle_t angle1, angle2, angle3, angle4;
  logic   nextangle;
  logic   at_target;
  modport master (
    output tgt_valid, tgt_angle1, tgt_angle2, tgt_angle3, tgt_angle4,
    input  tgt_ready, angle1, angle2, angle3, angle4, nextangle, at_target
  );
  modport slave (
    input  tgt_valid, tgt_angle1, tgt_angle2, tgt_angle3, tgt_angle4,
    output tgt_ready, angle1, angle2, angle3, angle4, nextangle, at_target
  );
endinterface

// File: rtl/servo_angle_ramp_slew.sv
// angle_slew_step: combinational next angle (cur, tgt, step in; nxt out), moving cur toward tgt by at most step without overshoot
module angle_slew_step
  import servo_pkg::*;
(
  input  angle_t cur,
  input  angle_t tgt,
  input  angle_t step,
  output angle_t nxt
);
  logic signed [8:0] d;
  logic [8:0] mag;
  assign d = $signed({1'b0, tgt}) - $signed({1'b0, cur});
  assign mag = d[8] ? -d : d;
  assign nxt = (mag <= {1'b0, step}) ? tgt : d[8] ? cur - step : cur + step;
endmodule

// File: rtl/servo_angle_ramp.sv
// servo_angle_ramp: slews four servo angles toward handshaked targets once per frame (clk, rst, bus slave: targets in, angle1..4/nextangle/at_target out)
module servo_angle_ramp #(
  parameter int FRAME_CYCLES = 1000001,
  parameter int STEP = 2,
  parameter int HOME_ANGLE = 90
) (
  input logic clk,
  input logic rst,
  servo_angle_ramp_if.slave bus
);
  import servo_pkg::*;
  if (STEP < 1 || STEP > MAX_ANGLE) begin : g_bad_step
    $error("STEP must be within 1..180");
  end
  if (FRAME_CYCLES < 4 || FRAME_CYCLES > (1 << 20)) begin : g_bad_frame
    $error("FRAME_CYCLES must be within 4..2^20");
  end
  if (HOME_ANGLE < 0 || HOME_ANGLE > MAX_ANGLE) begin : g_bad_home
    $error("HOME_ANGLE must be within 0..180");
  end
  localparam angle_t HOME = angle_t'(HOME_ANGLE);
  ramp_state_t state;
  logic [19:0] fcnt;
  logic tick, acc, update, init_pending, strobe, done;
  logic diff, hit_nxt, hit_in;
  angle_t tgt_in [NUM_SERVOS];
  angle_t cur [NUM_SERVOS];
  angle_t tgt [NUM_SERVOS];
  angle_t nxt [NUM_SERVOS];
  assign tick = fcnt == 20'(FRAME_CYCLES - 1);
  assign acc = bus.tgt_valid && bus.tgt_ready;
  assign update = diff || init_pending;
  assign tgt_in = '{clamp_angle(bus.tgt_angle1), clamp_angle(bus.tgt_angle2),
                    clamp_angle(bus.tgt_angle3), clamp_angle(bus.tgt_angle4)};
  assign bus.tgt_ready = state != servo_pkg::STEP;
  assign bus.nextangle = strobe;
  assign bus.at_target = done;
  assign bus.angle1 = cur[0];
  assign bus.angle2 = cur[1];
  assign bus.angle3 = cur[2];
  assign bus.angle4 = cur[3];
  genvar i;
  for (i = 0; i < NUM_SERVOS; i++) begin : g_ch
    angle_slew_step u_slew (
      .cur  (cur[i]),
      .tgt  (tgt[i]),
      .step (angle_t'(STEP)),
      .nxt  (nxt[i])
    );
  end
  always_comb begin
    diff = 1'b0;
    hit_nxt = 1'b1;
    hit_in = 1'b1;
    for (int k = 0; k < NUM_SERVOS; k++) begin
      diff = diff | (cur[k] != tgt[k]);
      hit_nxt = hit_nxt & (nxt[k] == tgt[k]);
      hit_in = hit_in & (cur[k] == tgt_in[k]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      fcnt <= '0;
      state <= WAIT;
      strobe <= 1'b0;
      done <= 1'b1;
      init_pending <= 1'b1;
      for (int k = 0; k < NUM_SERVOS; k++) begin
        cur[k] <= HOME;
        tgt[k] <= HOME;
      end
    end else begin
      fcnt <= tick ? '0 : fcnt + 20'd1;
      if (acc) begin
        tgt <= tgt_in;
        done <= hit_in;
      end
      case (state)
        WAIT: state <= tick ? servo_pkg::STEP : WAIT;
        servo_pkg::STEP: begin
          cur <= nxt;
          done <= hit_nxt;
          strobe <= update;
          state <= update ? PULSE : WAIT;
        end
        PULSE: begin
          strobe <= 1'b0;
          init_pending <= 1'b0;
          state <= WAIT;
        end
        default: state <= WAIT;
      endcase
    end
  end
endmodule
